tx_mac_arbiter: RTL
===================

# tx_mac_arbiter

Frame-granular round-robin arbiter that shares the single TX MAC AXI-stream input between two frame sources (e.g. UDP/IP path and a raw/ARP path). It grants one source per complete frame and passes that frame through to the MAC with zero added latency. It enforces a minimum idle gap between frames and truncates oversize frames by flagging them with an error and discarding the remainder.

## Interface
- DATA_WIDTH, 8: byte-stream width.
- IFG_CYCLES, 12: idle cycles inserted after each frame's last beat before the next grant; range 0..255.
- MAX_FRAME, 1518: maximum beats per frame before truncation; range 64..65535.
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- s0_tx_axis_tdata  in  DATA_WIDTH  source 0 data.
- s0_tx_axis_tvalid  in  1  source 0 valid.
- s0_tx_axis_tlast  in  1  source 0 last beat.
- s0_tx_axis_tuser  in  1  source 0 error flag.
- s0_tx_axis_trdy  out  1  ready to source 0.
- s1_tx_axis_tdata / tvalid / tlast / tuser / trdy: same set for source 1.
- m_tx_axis_tdata  out  DATA_WIDTH  data to MAC.
- m_tx_axis_tvalid  out  1  valid to MAC.
- m_tx_axis_tlast  out  1  last beat to MAC.
- m_tx_axis_tuser  out  1  error/abort to MAC.
- m_tx_axis_trdy  in  1  MAC ready.
- grant  out  2  one-hot current owner; 00 when none.
- trunc_evt  out  1  one-cycle pulse when a frame is truncated.

## Operation
- **States:** IDLE, XFER, DROP, GAP.
- **IDLE:** no grant.
  - If exactly one source has tvalid high, grant it.
  - If both are high, grant the source indicated by the round-robin pointer `rr`.
  - Go to XFER on the next edge.
- **XFER:** combinational pass-through of the granted source.
  - m_tx_* equals s<g>_tx_* (data/valid/last/user).
  - s<g>_tx_axis_trdy = m_tx_axis_trdy; the non-granted trdy is 0.
  - Beat = tvalid && trdy. A 16-bit beat counter increments per beat.
- **Normal end:** on a beat with tlast, go to GAP. `rr` points to the other source.
- **Truncation:** when beat MAX_FRAME is accepted without tlast:
  - That beat goes out with m_tx_axis_tlast=1 and m_tx_axis_tuser=1, forced.
  - trunc_evt pulses and the state goes to DROP.
- **DROP:** MAC outputs are idle (tvalid=0).
  - The granted source's trdy is held at 1, sinking its beats until its tlast beat.
  - Then go to GAP.
- **GAP:** load the counter with IFG_CYCLES and count down to 0, then go to IDLE. With IFG_CYCLES=0, GAP lasts one cycle.
- **Ownership:** a granted source keeps ownership while its tvalid is low mid-frame. There is no timeout.
- **Source error:** source tuser is forwarded unmodified. It does not end the frame; only tlast ends it.

## Timing
- **Reset values:** state=IDLE, rr=0, grant=00, counters=0, trunc_evt=0. All m_tx_* outputs and both s*_trdy are 0.
- **Latency:** 0 cycles data latency in XFER.
- **Arbitration:** one cycle from request seen in IDLE to first possible beat.
- **Back-to-back frames:** the minimum spacing from a tlast beat to the next first beat is IFG_CYCLES + 2 cycles (1 GAP-exit cycle + 1 IDLE-grant cycle).
- **Fairness:** `rr` flips only on frame end, whether normal or truncation-drop end.
  - Two continuously requesting sources therefore alternate strictly, starting with s0 after reset.
- **Simultaneous tlast and MAX_FRAME on the same beat:** treat as a normal end. No tuser, no trunc_evt.
- **tvalid dropped in IDLE:** requests seen in IDLE are sampled at the grant edge. If the requester's tvalid drops after grant, it still owns the bus.
- **Reset mid-frame:** everything returns to reset values immediately, asynchronously. The partial frame is not terminated on m_tx.

## Structure
- **Package tx_arb_pkg:**
  - state enum (IDLE, XFER, DROP, GAP).
  - localparam widths for the beat counter (16) and gap counter (8).
- **Sub-module rr_arbiter2:** 2-requester round-robin grant logic with a priority pointer and an update strobe. It is reusable for later multi-source arbitration.
- **Top level:** FSM, counters and output mux.

## Test plan
- **Single source:** s0 sends a 64-beat frame with the MAC always ready.
  - Output data matches beat-for-beat and tlast arrives on beat 64. grant=01 throughout.
  - Then 12 GAP cycles.
- **Contention:** both sources continuously send 64-beat frames.
  - Grant order is s0, s1, s0, s1.
  - Idle spacing between each tlast and the next first beat is exactly 14 cycles.
- **Backpressure:** toggle m_tx_axis_trdy every other cycle during a 100-beat s1 frame.
  - No beats are lost or duplicated, and s0_trdy stays 0.
- **Truncation:** with MAX_FRAME=64, s0 sends 80 beats.
  - Beat 64 goes out with tlast=1, tuser=1 and trunc_evt pulses.
  - Beats 65–80 are absorbed with m_tx_axis_tvalid=0, then GAP.
- **Boundary:** with MAX_FRAME=64, send a 64-beat frame with tlast on beat 64.
  - Normal end: tuser=0, no trunc_evt.
- **Reset mid-frame:** assert reset at beat 30 of an s1 frame.
  - All outputs go to 0 immediately.
  - After release, with both sources requesting, s0 is granted first.

Source files
------------

// File: rtl/tx_arb_pkg.sv
// Shared types for the TX MAC frame arbiter: FSM state encoding and counter widths.
// No logic here; latency and backpressure live in the modules that import it.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DROP = 2'd2,
    GAP  = 2'd3
  } arb_state_e;

  localparam int BEAT_CNT_W = 16;
  localparam int GAP_CNT_W  = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant with a registered priority pointer.
// Grant is combinational (0 latency); the pointer moves only on the upd strobe.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic [1:0] last_gnt,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    // Priority passes to whichever source did not just finish.
    if (upd) begin
      ptr_d = last_gnt[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/tx_mac_arbiter.sv
// Frame-granular round-robin mux of two AXI-stream sources onto the TX MAC, with IFG and truncation.
// Zero-cycle pass-through in XFER; MAC trdy is routed straight back to the granted source only.
module tx_mac_arbiter
  import tx_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IFG_CYCLES = 12,
  parameter int MAX_FRAME  = 1518
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s0_tx_axis_tdata,
  input  logic                  s0_tx_axis_tvalid,
  input  logic                  s0_tx_axis_tlast,
  input  logic                  s0_tx_axis_tuser,
  output logic                  s0_tx_axis_trdy,
  input  logic [DATA_WIDTH-1:0] s1_tx_axis_tdata,
  input  logic                  s1_tx_axis_tvalid,
  input  logic                  s1_tx_axis_tlast,
  input  logic                  s1_tx_axis_tuser,
  output logic                  s1_tx_axis_trdy,
  output logic [DATA_WIDTH-1:0] m_tx_axis_tdata,
  output logic                  m_tx_axis_tvalid,
  output logic                  m_tx_axis_tlast,
  output logic                  m_tx_axis_tuser,
  input  logic                  m_tx_axis_trdy,
  output logic [1:0]            grant,
  output logic                  trunc_evt
);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT_IDX = BEAT_CNT_W'(MAX_FRAME - 1);
  localparam logic [BEAT_CNT_W-1:0] BEAT_ONE      = BEAT_CNT_W'(1);
  localparam logic [GAP_CNT_W-1:0]  GAP_LOAD      = GAP_CNT_W'(IFG_CYCLES);
  localparam logic [GAP_CNT_W-1:0]  GAP_ONE       = GAP_CNT_W'(1);

  arb_state_e              state_q, state_d;
  logic [1:0]              owner_q, owner_d;
  logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [GAP_CNT_W-1:0]    gap_cnt_q, gap_cnt_d;

  logic [1:0]              arb_gnt;
  logic                    rr_upd;
  logic [1:0]              s_rdy;
  logic                    force_trunc;

  logic                    sel;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_vld;
  logic                    sel_last;
  logic                    sel_user;

  rr_arbiter2 u_rr (
    .clk      (clk),
    .reset    (reset),
    .req      ({s1_tx_axis_tvalid, s0_tx_axis_tvalid}),
    .upd      (rr_upd),
    .last_gnt (owner_q),
    .gnt      (arb_gnt)
  );

  assign sel      = owner_q[1];
  assign sel_data = sel ? s1_tx_axis_tdata  : s0_tx_axis_tdata;
  assign sel_vld  = sel ? s1_tx_axis_tvalid : s0_tx_axis_tvalid;
  assign sel_last = sel ? s1_tx_axis_tlast  : s0_tx_axis_tlast;
  assign sel_user = sel ? s1_tx_axis_tuser  : s0_tx_axis_tuser;

  assign s0_tx_axis_trdy = s_rdy[0];
  assign s1_tx_axis_trdy = s_rdy[1];

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    beat_cnt_d       = beat_cnt_q;
    gap_cnt_d        = gap_cnt_q;
    rr_upd           = 1'b0;
    s_rdy            = 2'b00;
    force_trunc      = 1'b0;
    grant            = 2'b00;
    trunc_evt        = 1'b0;
    m_tx_axis_tdata  = '0;
    m_tx_axis_tvalid = 1'b0;
    m_tx_axis_tlast  = 1'b0;
    m_tx_axis_tuser  = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_gnt != 2'b00) begin
          owner_d    = arb_gnt;
          beat_cnt_d = '0;
          state_d    = XFER;
        end
      end

      XFER: begin
        grant            = owner_q;
        // A real tlast on the MAX_FRAME beat wins: that is a normal end.
        force_trunc      = (beat_cnt_q == LAST_BEAT_IDX) && !sel_last;
        m_tx_axis_tdata  = sel_data;
        m_tx_axis_tvalid = sel_vld;
        m_tx_axis_tlast  = sel_last | force_trunc;
        m_tx_axis_tuser  = sel_user | force_trunc;
        s_rdy            = owner_q & {2{m_tx_axis_trdy}};
        if (sel_vld && m_tx_axis_trdy) begin
          beat_cnt_d = beat_cnt_q + BEAT_ONE;
          if (sel_last) begin
            state_d   = GAP;
            gap_cnt_d = GAP_LOAD;
            rr_upd    = 1'b1;
          end else if (force_trunc) begin
            state_d   = DROP;
            trunc_evt = 1'b1;
          end
        end
      end

      DROP: begin
        // Sink the rest of the oversize frame without touching the MAC.
        grant = owner_q;
        s_rdy = owner_q;
        if (sel_vld && sel_last) begin
          state_d   = GAP;
          gap_cnt_d = GAP_LOAD;
          rr_upd    = 1'b1;
        end
      end

      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d    = IDLE;
          owner_d    = 2'b00;
          beat_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= 2'b00;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

endmodule
